// File: rtl/branch_target_buffer_pkg.sv
// Shared constants and helpers for the branch target buffer: address split
// widths and the saturating-counter encoding.
package branch_target_buffer_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] CTR_SAT_MIN = 4'd0;

  // Counter encodings are returned 4 bits wide (the widest legal counter)
  // and sliced down by the user.
  function automatic logic [3:0] ctr_sat_max(input int bits);
    return 4'((1 << bits) - 1);
  endfunction

  function automatic logic [3:0] ctr_weak_taken(input int bits);
    return 4'(1 << (bits - 1));
  endfunction

  function automatic int idx_bits(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_bits(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Next-value function of a W-bit up/down saturating counter.
module sat_counter_update
  import branch_target_buffer_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr_i,
  input  logic         inc_i,
  output logic [W-1:0] ctr_o
);

  localparam logic [3:0]   MAX4 = ctr_sat_max(W);
  localparam logic [3:0]   MIN4 = CTR_SAT_MIN;
  localparam logic [W-1:0] MAX  = MAX4[W-1:0];
  localparam logic [W-1:0] MIN  = MIN4[W-1:0];

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != MAX) ctr_o = ctr_i + 1'b1;
    end else begin
      if (ctr_i != MIN) ctr_o = ctr_i - 1'b1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped, flop-based branch target buffer with zero-latency lookup,
// resolve-stage mispredict detection and lookup/mispredict counters.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            flush_all,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic [XLEN-1:0] upd_pred_target,
  input  logic            upd_taken,
  input  logic            upd_pred_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     lookup_cnt,
  output logic [31:0]     mispredict_cnt
);

  localparam int IDX  = idx_bits(ENTRIES);
  localparam int TAGW = tag_bits(XLEN, ENTRIES);
  localparam logic [3:0]          WEAK4    = ctr_weak_taken(CTR_BITS);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = WEAK4[CTR_BITS-1:0];

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAGW-1:0]     tag_q    [ENTRIES];
  logic [TAGW-1:0]     tag_d    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [XLEN-1:0]     target_d [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d    [ENTRIES];
  logic                first_q, first_d;
  logic [31:0]         lookup_cnt_q, lookup_cnt_d;
  logic [31:0]         mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX-1:0]      lk_idx, upd_idx;
  logic [TAGW-1:0]     lk_tag, upd_tag;
  logic                upd_hit, upd_en;
  logic [CTR_BITS-1:0] ctr_next;

  assign lk_idx  = lookup_pc[IDX+1:2];
  assign lk_tag  = lookup_pc[XLEN-1:IDX+2];
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX+2];

  // Lookup reads the current (pre-update) table contents; no write bypass.
  assign pred_hit    = lookup_valid & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit & ctr_q[lk_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + XLEN'(4);

  assign mispredict  = upd_valid & ((upd_taken != upd_pred_taken) |
                                    (upd_taken & (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  // first_q drops the update that lands on the edge right after reset release.
  assign upd_en  = upd_valid & ~hold & ~flush_all & ~first_q;

  sat_counter_update #(.W(CTR_BITS)) u_sat_counter (
    .ctr_i (ctr_q[upd_idx]),
    .inc_i (upd_taken),
    .ctr_o (ctr_next)
  );

  always_comb begin
    valid_d          = valid_q;
    tag_d            = tag_q;
    target_d         = target_q;
    ctr_d            = ctr_q;
    first_d          = 1'b0;
    lookup_cnt_d     = lookup_cnt_q + 32'(lookup_valid & ~hold);
    mispredict_cnt_d = mispredict_cnt_q + 32'(mispredict & ~hold);
    if (flush_all) begin
      valid_d = '0;
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = ctr_next;
        if (upd_taken) target_d[upd_idx] = upd_target;
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = CTR_WEAK;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q          <= '0;
      first_q          <= 1'b1;
      lookup_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else begin
      valid_q          <= valid_d;
      first_q          <= first_d;
      lookup_cnt_q     <= lookup_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      tag_q            <= tag_d;
      target_q         <= target_d;
      ctr_q            <= ctr_d;
    end
  end

  assign lookup_cnt     = lookup_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule
